multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM controller for the multi-cycle MIPS datapath. It replaces the single-cycle combinational control with a controller that steps each instruction through FETCH/DECODE/execute states.
- Stalls on a variable-latency memory (`mem_ready`) and traps illegal opcodes.
- Drives the shared-memory datapath: PC, IR, register file, ALU and memory muxes.

Parameters:
- MAX_WAIT, 0: memory-wait timeout in cycles; 0 = wait forever.
- TOW, 8: width of the wait timer; must satisfy MAX_WAIT < 2**TOW.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct
- state  out  4  current state, for debug
- instr_done  out  1  pulse in the last cycle of each instruction
- illegal_op  out  1  pulse in TRAP
- mem_timeout  out  1  pulse on wait abort

Behaviour:
- States (4-bit): RESET=0, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP. Codes 14-15 are unreachable and recover to FETCH.
- rst low: state = RESET, all outputs 0, wait timer 0. The first cycle after release is RESET (outputs 0), then FETCH.
- Any control not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE: ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 0x23 or 0x2B → MEM_ADDR
  - 0x00 → EXECUTE
  - 0x04 or 0x05 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EX
  - anything else → TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Go to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: MemRead=1, IorD=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0, instr_done=1. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for mem_ready; instr_done=mem_ready; then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then R_WB.
- R_WB: RegDst=1, RegWrite=1, instr_done=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=(opcode==0x05), instr_done=1. Then FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Then FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10. Then ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, instr_done=1. Then FETCH.
- TRAP: illegal_op=1, no writes. Then FETCH; PC has already advanced by 4.
- Latency with mem_ready held at 1: lw 5 cycles; R-type, sw and addi 4; beq, bne and j 3.
- Wait timer (FETCH, MEM_READ, MEM_WRITE):
  - Clears on state entry; counts each cycle mem_ready=0.
  - If MAX_WAIT≠0 and the count reaches MAX_WAIT with mem_ready=0: mem_timeout=1 that cycle, next state FETCH.
  - No IRWrite, PCWrite, RegWrite or instr_done is issued on the abort.
  - mem_ready=1 in the timeout cycle wins: normal completion, no timeout.
- Reset asserted in any state aborts immediately; no partial write is completed.

Optional Feature:
- MCU_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] (+1 every cycle state≠RESET) and instr_cnt[CNT_W-1:0] (+1 per instr_done).
  - Both reset to 0 and wrap modulo 2**CNT_W.
- MCU_PERF_CNT_EN undefined: counter ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package mcu_pkg holds:
  - state localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI;
  - ALUOp, PCSource and ALUSrcB encodings.
- One sub-module, mcu_wait_timer (TOW, MAX_WAIT): inputs clear, count enable, mem_ready; output timeout.

Test Plan:
- Reset sequence: rst=0 for 3 cycles, then 1 → all outputs 0; state RESET→FETCH (1) one cycle after release.
- R-type: opcode=0x00, mem_ready=1 → states FETCH, DECODE, EXECUTE, R_WB. RegDst=RegWrite=1 in cycle 4, instr_done pulses once.
- lw with memory stall:
  - Stimulus: opcode=0x23, mem_ready low for 3 cycles in MEM_READ.
  - Response: 8 cycles total; RegWrite=MemToReg=1 only in MEM_WB.
- bne and j:
  - bne (0x05) → BRANCH has PCWriteCond=1, BranchNE=1, PCSource=01.
  - j (0x02) → PCWrite=1, PCSource=10; each takes 3 cycles.
- Illegal opcode: opcode=0x3F → TRAP with illegal_op=1 for 1 cycle, no RegWrite/MemWrite, then FETCH.
- Timeout and mid-operation reset:
  - MAX_WAIT=4, mem_ready=0 in MEM_WRITE → mem_timeout on wait cycle 4, MemWrite drops, then FETCH, instr_done never asserted.
  - rst=0 mid-MEM_WRITE → all outputs 0 immediately.

Source files
------------

// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - state, opcode and datapath-select encodings for the multi-cycle controller
package mcu_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_ADDI_WB   = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mcu_wait_timer.sv
// rtl/mcu_wait_timer.sv - memory-wait timer; timeout fires on the MAX_WAIT-th stalled cycle
module mcu_wait_timer #(
  parameter int MAX_WAIT = 0,
  parameter int TOW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TOW:0] LIMIT = (TOW+1)'(MAX_WAIT);

  logic [TOW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !mem_ready) begin
      cnt <= cnt + TOW'(1);
    end
  end

  // cnt holds the stalled cycles already seen, so this cycle is stall number cnt+1
  assign timeout = (MAX_WAIT != 0) && en && !mem_ready &&
                   (({1'b0, cnt} + (TOW+1)'(1)) == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle MIPS controller FSM; MCU_PERF_CNT_EN adds cycle/instr counters
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int TOW      = 8,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  if (CNT_W < 1 || TOW < 1 || MAX_WAIT < 0 || MAX_WAIT >= (1 << TOW)) begin : g_bad_params
    $error("multicycle_control_unit: invalid CNT_W/TOW/MAX_WAIT");
  end

  state_t state_q;
  state_t state_d;
  logic   wait_en;
  logic   timeout;
  logic   timer_clear;

  assign wait_en     = (state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                       (state_q == ST_MEM_WRITE);
  // A timeout re-enters FETCH, possibly from FETCH itself, so it must also clear the count
  assign timer_clear = (state_d != state_q) || timeout;
  assign mem_timeout = timeout;
  assign state       = state_q;

  mcu_wait_timer #(.MAX_WAIT(MAX_WAIT), .TOW(TOW)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .en        (wait_en),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PC_ALU;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
          OP_RTYPE:       state_d = ST_EXECUTE;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:           state_d = ST_JUMP;
          OP_ADDI:        state_d = ST_ADDI_EX;
          default:        state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = ST_MEM_WB;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready || timeout) state_d = ST_FETCH;
      end
      ST_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = ST_R_WB;
      end
      ST_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PC_ALUOUT;
        BranchNE    = (opcode == OP_BNE);
        instr_done  = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PC_JUMP;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_op = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != ST_RESET) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - per-cycle vector bench for the multi-cycle controller
module tb_multicycle_control_unit;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MADDR = 4'd3;
  localparam logic [3:0] S_MREAD = 4'd4,  S_MWB = 4'd5,    S_MWRITE = 4'd6,  S_EXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8,    S_BRANCH = 4'd9, S_JUMP = 4'd10,   S_AEX = 4'd11;
  localparam logic [3:0] S_AWB = 4'd12,   S_TRAP = 4'd13;

  // {PCWrite,PCWriteCond,BranchNE,IorD,MemRead,MemWrite,MemToReg,IRWrite,ALUSrcA,RegWrite,RegDst}
  // _ PCSource _ ALUSrcB _ ALUOp _ {instr_done,illegal_op,mem_timeout}
  localparam logic [19:0] C_ZERO   = 20'b00000000000_00_00_00_000;
  localparam logic [19:0] C_F_RDY  = 20'b10001001000_00_01_00_000;
  localparam logic [19:0] C_F_WAIT = 20'b00001000000_00_01_00_000;
  localparam logic [19:0] C_F_TO   = 20'b00001000000_00_01_00_001;
  localparam logic [19:0] C_DEC    = 20'b00000000000_00_11_00_000;
  localparam logic [19:0] C_MADDR  = 20'b00000000100_00_10_00_000;
  localparam logic [19:0] C_MRD    = 20'b00011000000_00_00_00_000;
  localparam logic [19:0] C_MRD_TO = 20'b00011000000_00_00_00_001;
  localparam logic [19:0] C_MWB    = 20'b00000010010_00_00_00_100;
  localparam logic [19:0] C_MW_RDY = 20'b00010100000_00_00_00_100;
  localparam logic [19:0] C_MW_WT  = 20'b00010100000_00_00_00_000;
  localparam logic [19:0] C_MW_TO  = 20'b00010100000_00_00_00_001;
  localparam logic [19:0] C_EXEC   = 20'b00000000100_00_00_10_000;
  localparam logic [19:0] C_RWB    = 20'b00000000011_00_00_00_100;
  localparam logic [19:0] C_BEQ    = 20'b01000000100_01_00_01_100;
  localparam logic [19:0] C_BNE    = 20'b01100000100_01_00_01_100;
  localparam logic [19:0] C_JUMP   = 20'b10000000000_10_00_00_100;
  localparam logic [19:0] C_AEX    = 20'b00000000100_00_10_00_000;
  localparam logic [19:0] C_AWB    = 20'b00000000010_00_00_00_100;
  localparam logic [19:0] C_TRAP   = 20'b00000000000_00_00_00_010;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode;
  logic mem_ready;
  logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemToReg;
  logic IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic instr_done, illegal_op, mem_timeout;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit #(.MAX_WAIT(4), .TOW(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef MCU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  logic [19:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemToReg,
                 IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
                 instr_done, illegal_op, mem_timeout};

  typedef struct packed {
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [19:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [19:0] c, input int n = 1);
    vec_t v;
    v.opcode = op; v.mem_ready = mr; v.exp_state = st; v.exp_ctrl = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // inputs are driven 1 time unit after a rising edge and outputs sampled on the falling edge
  task automatic run_vec(input vec_t v, input string tag);
    opcode = v.opcode;
    mem_ready = v.mem_ready;
    @(negedge clk);
    check({tag, " state"}, {16'b0, state}, {16'b0, v.exp_state});
    check({tag, " ctrl"}, ctrl, v.exp_ctrl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; opcode = 6'h00; mem_ready = 1'b0;

    add(6'h00, 1, S_RESET, C_ZERO);
    // R-type
    add(6'h00, 1, S_FETCH, C_F_RDY); add(6'h00, 1, S_DECODE, C_DEC);
    add(6'h00, 1, S_EXEC, C_EXEC);   add(6'h00, 1, S_RWB, C_RWB);
    // lw with three stalled cycles in MEM_READ: 8 cycles
    add(6'h23, 1, S_FETCH, C_F_RDY); add(6'h23, 1, S_DECODE, C_DEC);
    add(6'h23, 1, S_MADDR, C_MADDR); add(6'h23, 0, S_MREAD, C_MRD, 3);
    add(6'h23, 1, S_MREAD, C_MRD);   add(6'h23, 1, S_MWB, C_MWB);
    // bne, j, beq
    add(6'h05, 1, S_FETCH, C_F_RDY); add(6'h05, 1, S_DECODE, C_DEC); add(6'h05, 1, S_BRANCH, C_BNE);
    add(6'h02, 1, S_FETCH, C_F_RDY); add(6'h02, 1, S_DECODE, C_DEC); add(6'h02, 1, S_JUMP, C_JUMP);
    add(6'h04, 1, S_FETCH, C_F_RDY); add(6'h04, 1, S_DECODE, C_DEC); add(6'h04, 1, S_BRANCH, C_BEQ);
    // addi behind a two-cycle fetch stall
    add(6'h08, 0, S_FETCH, C_F_WAIT, 2); add(6'h08, 1, S_FETCH, C_F_RDY);
    add(6'h08, 1, S_DECODE, C_DEC); add(6'h08, 1, S_AEX, C_AEX); add(6'h08, 1, S_AWB, C_AWB);
    // sw without stall
    add(6'h2B, 1, S_FETCH, C_F_RDY); add(6'h2B, 1, S_DECODE, C_DEC);
    add(6'h2B, 1, S_MADDR, C_MADDR); add(6'h2B, 1, S_MWRITE, C_MW_RDY);
    // illegal opcode
    add(6'h3F, 1, S_FETCH, C_F_RDY); add(6'h3F, 1, S_DECODE, C_DEC); add(6'h3F, 1, S_TRAP, C_TRAP);
    // sw timeout on the fourth stalled cycle
    add(6'h2B, 1, S_FETCH, C_F_RDY); add(6'h2B, 1, S_DECODE, C_DEC); add(6'h2B, 1, S_MADDR, C_MADDR);
    add(6'h2B, 0, S_MWRITE, C_MW_WT, 3); add(6'h2B, 0, S_MWRITE, C_MW_TO);
    // fetch timeout, then the count restarts
    add(6'h00, 0, S_FETCH, C_F_WAIT, 3); add(6'h00, 0, S_FETCH, C_F_TO);
    add(6'h00, 0, S_FETCH, C_F_WAIT);    add(6'h00, 1, S_FETCH, C_F_RDY);
    add(6'h00, 1, S_DECODE, C_DEC); add(6'h00, 1, S_EXEC, C_EXEC); add(6'h00, 1, S_RWB, C_RWB);
    // mem_ready in the would-be timeout cycle completes normally
    add(6'h2B, 1, S_FETCH, C_F_RDY); add(6'h2B, 1, S_DECODE, C_DEC); add(6'h2B, 1, S_MADDR, C_MADDR);
    add(6'h2B, 0, S_MWRITE, C_MW_WT, 3); add(6'h2B, 1, S_MWRITE, C_MW_RDY);
    // lw timeout in MEM_READ
    add(6'h23, 1, S_FETCH, C_F_RDY); add(6'h23, 1, S_DECODE, C_DEC); add(6'h23, 1, S_MADDR, C_MADDR);
    add(6'h23, 0, S_MREAD, C_MRD, 3); add(6'h23, 0, S_MREAD, C_MRD_TO);

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("in_reset state", {16'b0, state}, 20'd0);
    check("in_reset ctrl", ctrl, C_ZERO);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset asserted in the middle of a stalled store
    run_vec({6'h2B, 1'b1, S_FETCH, C_F_RDY}, "mid_rst fetch");
    run_vec({6'h2B, 1'b1, S_DECODE, C_DEC}, "mid_rst decode");
    run_vec({6'h2B, 1'b1, S_MADDR, C_MADDR}, "mid_rst maddr");
    opcode = 6'h2B; mem_ready = 1'b0;
    @(negedge clk);
    check("mid_rst pre state", {16'b0, state}, {16'b0, S_MWRITE});
    check("mid_rst pre ctrl", ctrl, C_MW_WT);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst async state", {16'b0, state}, 20'd0);
    check("mid_rst async ctrl", ctrl, C_ZERO);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec({6'h00, 1'b1, S_RESET, C_ZERO}, "post_rst reset");
    run_vec({6'h00, 1'b1, S_FETCH, C_F_RDY}, "post_rst fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
